// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter with programmable modulus, wrap/saturate,
// parallel load, terminal-count pulse, sticky overflow and optional button synchroniser.
module param_updown_counter #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MODULUS   = 2**WIDTH,
  parameter bit          SYNC_STEP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  // Reject parameter sets that leave no legal count range.
  if (WIDTH < 1 || MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_param
    $error("param_updown_counter: MODULUS must lie in 2..2**WIDTH");
  end

  logic [2:0]       sync_q;
  logic             step_ev;
  logic             cnt_ev;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;

  // Two-flop synchroniser plus edge-detect flop; unused when the strobe is already synchronous.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], step};
    end
  end

  assign step_ev = SYNC_STEP ? (sync_q[1] & ~sync_q[2]) : step;
  assign cnt_ev  = step_ev & en;

  // Next-state: load beats count event beats hold; tc defaults low so it is a one-cycle pulse.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf;
    if (load) begin
      count_nxt = (load_val > MAX) ? MAX : load_val;
      ovf_nxt   = 1'b0;
    end else if (cnt_ev) begin
      if (up) begin
        if (count == MAX) begin
          count_nxt = sat_mode ? MAX : '0;
          tc_nxt    = 1'b1;
          ovf_nxt   = 1'b1;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          count_nxt = sat_mode ? '0 : MAX;
          tc_nxt    = 1'b1;
          ovf_nxt   = 1'b1;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign at_max = (count == MAX);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter: three instances (natural 3-bit,
// modulo-10 strobe, modulo-10 button) sharing one stimulus set.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       step = 1'b0;
  logic       en = 1'b1;
  logic       up = 1'b1;
  logic       sat_mode = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [2:0] cnt3;
  logic       tc3, ovf3, amax3, amin3;
  logic [3:0] cnt10;
  logic       tc10, ovf10, amax10, amin10;
  logic [3:0] cntb;
  logic       tcb, ovfb, amaxb, aminb;

  typedef struct {
    logic [3:0] cnt;
    logic       tc;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(3), .MODULUS(8), .SYNC_STEP(1'b0)) u_d3 (
    .clk(clk), .reset(reset), .step(step), .en(en), .up(up), .sat_mode(sat_mode),
    .load(load), .load_val(load_val[2:0]), .count(cnt3), .tc(tc3), .ovf(ovf3),
    .at_max(amax3), .at_min(amin3));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SYNC_STEP(1'b0)) u_d10 (
    .clk(clk), .reset(reset), .step(step), .en(en), .up(up), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .count(cnt10), .tc(tc10), .ovf(ovf10),
    .at_max(amax10), .at_min(amin10));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SYNC_STEP(1'b1)) u_btn (
    .clk(clk), .reset(reset), .step(step), .en(en), .up(up), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .count(cntb), .tc(tcb), .ovf(ovfb),
    .at_max(amaxb), .at_min(aminb));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; step = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    sat_mode = 1'b0; load_val = 4'd0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0; step = 1'b0;
    cyc(); cyc();
    checks++;
    if ({cnt3, tc3, ovf3, cnt10, tc10, ovf10, cntb, tcb, ovfb} !== 17'd0) begin
      errors++;
      $display("FAIL reset_hold got d3=%0d/%0b/%0b d10=%0d/%0b/%0b btn=%0d/%0b/%0b exp all zero",
               cnt3, tc3, ovf3, cnt10, tc10, ovf10, cntb, tcb, ovfb);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) sb.push_back('{cnt: 4'd0, tc: 1'b0, ovf: 1'b0});
    for (int i = 0; i < 10; i++) begin
      cyc();
      e = sb.pop_front();
      checks++;
      if ({1'b0, cnt3, tc3, ovf3, amin3, amax3} !== {e.cnt, e.tc, e.ovf, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle[%0d] got cnt=%0d tc=%0b ovf=%0b at_min=%0b at_max=%0b exp cnt=%0d tc=%0b ovf=%0b at_min=1 at_max=0",
                 i, cnt3, tc3, ovf3, amin3, amax3, e.cnt, e.tc, e.ovf);
      end
    end
  endtask

  task automatic test_natural_wrap();
    do_reset();
    up = 1'b1; sat_mode = 1'b0;
    for (int i = 1; i <= 9; i++)
      sb.push_back('{cnt: 4'(i % 8), tc: 1'(i == 8), ovf: 1'(i >= 8)});
    step = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      e = sb.pop_front();
      checks++;
      if ({1'b0, cnt3, tc3, ovf3, amax3} !== {e.cnt, e.tc, e.ovf, 1'(i == 7)}) begin
        errors++;
        $display("FAIL natural_wrap[%0d] got cnt=%0d tc=%0b ovf=%0b at_max=%0b exp cnt=%0d tc=%0b ovf=%0b at_max=%0b",
                 i, cnt3, tc3, ovf3, amax3, e.cnt, e.tc, e.ovf, (i == 7));
      end
    end
    step = 1'b0;
  endtask

  task automatic test_wrap_up();
    do_reset();
    up = 1'b1; sat_mode = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      sb.push_back('{cnt: 4'(i % 10), tc: 1'(i == 10), ovf: 1'(i == 10)});
      sb.push_back('{cnt: 4'(i % 10), tc: 1'b0, ovf: 1'(i == 10)});
    end
    for (int i = 0; i < 20; i++) begin
      step = (i % 2 == 0);
      cyc();
      e = sb.pop_front();
      checks++;
      if ({cnt10, tc10, ovf10} !== {e.cnt, e.tc, e.ovf}) begin
        errors++;
        $display("FAIL wrap_up[%0d] got cnt=%0d tc=%0b ovf=%0b exp cnt=%0d tc=%0b ovf=%0b",
                 i, cnt10, tc10, ovf10, e.cnt, e.tc, e.ovf);
      end
    end
    step = 1'b0;
  endtask

  task automatic test_sat_down();
    do_reset();
    load = 1'b1; load_val = 4'd2;
    sb.push_back('{cnt: 4'd2, tc: 1'b0, ovf: 1'b0});
    sb.push_back('{cnt: 4'd1, tc: 1'b0, ovf: 1'b0});
    sb.push_back('{cnt: 4'd0, tc: 1'b0, ovf: 1'b0});
    sb.push_back('{cnt: 4'd0, tc: 1'b1, ovf: 1'b1});
    sb.push_back('{cnt: 4'd0, tc: 1'b1, ovf: 1'b1});
    sb.push_back('{cnt: 4'd0, tc: 1'b0, ovf: 1'b1});
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        load = 1'b0; up = 1'b0; sat_mode = 1'b1; step = 1'b1;
      end
      if (i == 5) step = 1'b0;
      cyc();
      e = sb.pop_front();
      checks++;
      if ({cnt10, tc10, ovf10, amin10} !== {e.cnt, e.tc, e.ovf, 1'(e.cnt == 4'd0)}) begin
        errors++;
        $display("FAIL sat_down[%0d] got cnt=%0d tc=%0b ovf=%0b at_min=%0b exp cnt=%0d tc=%0b ovf=%0b",
                 i, cnt10, tc10, ovf10, amin10, e.cnt, e.tc, e.ovf);
      end
    end
  endtask

  task automatic test_load_priority();
    // Entered with ovf=1 from the saturate test.
    sb.push_back('{cnt: 4'd9, tc: 1'b0, ovf: 1'b0});
    sb.push_back('{cnt: 4'd9, tc: 1'b0, ovf: 1'b0});
    sb.push_back('{cnt: 4'd0, tc: 1'b1, ovf: 1'b1});
    sb.push_back('{cnt: 4'd4, tc: 1'b0, ovf: 1'b0});
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin load = 1'b1; load_val = 4'd13; step = 1'b1; en = 1'b1; up = 1'b1; sat_mode = 1'b0; end
        1: begin load = 1'b0; en = 1'b0; end
        2: begin en = 1'b1; end
        default: begin load = 1'b1; load_val = 4'd4; en = 1'b0; end
      endcase
      cyc();
      e = sb.pop_front();
      checks++;
      if ({cnt10, tc10, ovf10} !== {e.cnt, e.tc, e.ovf}) begin
        errors++;
        $display("FAIL load_priority[%0d] got cnt=%0d tc=%0b ovf=%0b exp cnt=%0d tc=%0b ovf=%0b",
                 i, cnt10, tc10, ovf10, e.cnt, e.tc, e.ovf);
      end
    end
    load = 1'b0; step = 1'b0; en = 1'b1;
  endtask

  task automatic test_button();
    do_reset();
    cyc();
    step = 1'b1;
    for (int k = 1; k <= 20; k++) sb.push_back('{cnt: (k >= 3) ? 4'd1 : 4'd0, tc: 1'b0, ovf: 1'b0});
    for (int k = 1; k <= 3; k++) sb.push_back('{cnt: 4'd1, tc: 1'b0, ovf: 1'b0});
    for (int k = 1; k <= 4; k++) sb.push_back('{cnt: (k >= 3) ? 4'd2 : 4'd1, tc: 1'b0, ovf: 1'b0});
    for (int k = 1; k <= 27; k++) begin
      if (k == 21) step = 1'b0;
      if (k == 24) step = 1'b1;
      cyc();
      e = sb.pop_front();
      checks++;
      if ({cntb, tcb, ovfb} !== {e.cnt, e.tc, e.ovf}) begin
        errors++;
        $display("FAIL button[%0d] got cnt=%0d tc=%0b ovf=%0b exp cnt=%0d tc=%0b ovf=%0b",
                 k, cntb, tcb, ovfb, e.cnt, e.tc, e.ovf);
      end
    end
    // Step held high across reset release yields exactly one event.
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) sb.push_back('{cnt: (k >= 3) ? 4'd1 : 4'd0, tc: 1'b0, ovf: 1'b0});
    for (int k = 1; k <= 8; k++) begin
      cyc();
      e = sb.pop_front();
      checks++;
      if ({cntb, tcb, ovfb} !== {e.cnt, e.tc, e.ovf}) begin
        errors++;
        $display("FAIL button_rst_held[%0d] got cnt=%0d tc=%0b ovf=%0b exp cnt=%0d tc=%0b ovf=%0b",
                 k, cntb, tcb, ovfb, e.cnt, e.tc, e.ovf);
      end
    end
    step = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    load = 1'b1; load_val = 4'd5;
    cyc();
    load = 1'b0; step = 1'b1;
    cyc();
    checks++;
    if (cntb !== 4'd5) begin
      errors++;
      $display("FAIL mid_reset_pre got cnt=%0d exp cnt=5", cntb);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({cntb, tcb, ovfb, cnt10} !== {4'd0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL mid_reset_async got btn=%0d tc=%0b ovf=%0b d10=%0d exp btn=0 tc=0 ovf=0 d10=0",
               cntb, tcb, ovfb, cnt10);
    end
    step = 1'b0;
    #2;
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) sb.push_back('{cnt: 4'd0, tc: 1'b0, ovf: 1'b0});
    for (int k = 1; k <= 5; k++) begin
      cyc();
      e = sb.pop_front();
      checks++;
      if ({cntb, tcb, ovfb} !== {e.cnt, e.tc, e.ovf}) begin
        errors++;
        $display("FAIL mid_reset_after[%0d] got cnt=%0d tc=%0b ovf=%0b exp cnt=%0d tc=%0b ovf=%0b",
                 k, cntb, tcb, ovfb, e.cnt, e.tc, e.ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_natural_wrap();
    test_wrap_up();
    test_sat_down();
    test_load_priority();
    test_button();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
